// File: rtl/trace_packetizer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : trace_packetizer                                             |
// | Description : Turns filtered RAM-bus samples into address, read-word,      |
// |               write-word and timestamp packets, queued in a first-word     |
// |               fall-through valid/ready FIFO. Packets that find the FIFO    |
// |               full are dropped and later reported by an in-band marker.    |
// | Revision    : 1.0 - initial parameterised release                          |
// +----------------------------------------------------------------------------+
module trace_packetizer #(
  parameter int          ADDR_WIDTH    = 23,
  parameter int          DATA_WIDTH    = 16,
  parameter int          TS_SHORT_BITS = 5,
  parameter int          FIFO_DEPTH    = 16,
  parameter logic [15:0] CFG_ADDR      = 16'h0001,
  parameter int          READ_LATENCY  = 4,
  parameter int          WRITE_LATENCY = 3
) (
  input  logic                          mclk,
  input  logic                          reset,
  input  logic [15:0]                   config_addr,
  input  logic [15:0]                   config_data,
  input  logic                          config_strobe,
  input  logic [ADDR_WIDTH-1:0]         filter_a,
  input  logic [DATA_WIDTH-1:0]         filter_d,
  input  logic [DATA_WIDTH-1:0]         nfilter_d,
  input  logic [1:0]                    filter_ublb,
  input  logic                          filter_read,
  input  logic                          filter_write,
  input  logic                          filter_addr_latch,
  input  logic                          filter_strobe,
  output logic [1:0]                    packet_type,
  output logic [ADDR_WIDTH-1:0]         packet_payload,
  output logic                          packet_valid,
  input  logic                          packet_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          drop_pending
);

  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam int c_lvl_w = c_ptr_w + 1;
  localparam int c_pkt_w = ADDR_WIDTH + 2;

  localparam logic [1:0] c_type_addr  = 2'b00;
  localparam logic [1:0] c_type_read  = 2'b01;
  localparam logic [1:0] c_type_write = 2'b10;
  localparam logic [1:0] c_type_ts    = 2'b11;

  localparam logic [ADDR_WIDTH-1:0] c_ts5_max   = ADDR_WIDTH'((1 << TS_SHORT_BITS) - 1);
  localparam logic [ADDR_WIDTH-1:0] c_ts_one    = ADDR_WIDTH'(1);
  localparam logic [c_ptr_w-1:0]    c_ptr_one   = c_ptr_w'(1);
  localparam logic [c_lvl_w-1:0]    c_lvl_one   = c_lvl_w'(1);
  localparam logic [c_lvl_w-1:0]    c_lvl_full  = c_lvl_w'(FIFO_DEPTH);
  localparam logic [3:0]            c_rd_lat_rst = 4'(READ_LATENCY);
  localparam logic [3:0]            c_wr_lat_rst = 4'(WRITE_LATENCY);

  // Configuration fields
  logic       r_trace_reads;
  logic       r_trace_writes;
  logic [3:0] r_rd_lat;
  logic [3:0] r_wr_lat;

  // Tracing state
  logic [7:0]            r_burst;
  logic [ADDR_WIDTH-1:0] r_ts;
  logic [ADDR_WIDTH-2:0] r_drop_count;
  logic                  r_drop_pending;

  // FIFO storage
  logic [c_pkt_w-1:0] r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_lvl_w-1:0] r_level;

  // Combinational helpers
  logic                  w_trace_any;
  logic [3:0]            w_rd_lat_eff;
  logic [3:0]            w_wr_lat_eff;
  logic                  w_rd_due;
  logic                  w_wr_due;
  logic [ADDR_WIDTH-1:0] w_ts5_ext;
  logic [TS_SHORT_BITS-1:0] w_ts5;
  logic                  w_gen;
  logic [1:0]            w_gen_type;
  logic [ADDR_WIDTH-1:0] w_gen_payload;
  logic [ADDR_WIDTH-1:0] w_ts_next;
  logic                  w_full;
  logic                  w_drop;
  logic                  w_marker;
  logic                  w_push;
  logic                  w_pop;
  logic [c_pkt_w-1:0]    w_push_word;
  logic                  w_cfg_unused;

  // Config bits that carry no function still belong to the register word
  assign w_cfg_unused = &{1'b0, config_data[15:12], config_data[3:2]};

  assign w_trace_any  = r_trace_reads | r_trace_writes;
  // A latency of 0 behaves like 1 so the threshold never underflows
  assign w_rd_lat_eff = (r_rd_lat == 4'd0) ? 4'd1 : r_rd_lat;
  assign w_wr_lat_eff = (r_wr_lat == 4'd0) ? 4'd1 : r_wr_lat;
  assign w_rd_due     = r_burst >= ({4'd0, w_rd_lat_eff} - 8'd1);
  assign w_wr_due     = r_burst >= ({4'd0, w_wr_lat_eff} - 8'd1);
  assign w_ts5_ext    = (r_ts > c_ts5_max) ? c_ts5_max : r_ts;
  assign w_ts5        = w_ts5_ext[TS_SHORT_BITS-1:0];

  // Config register write; new values apply from the following cycle
  always_ff @(posedge mclk) begin
    if (reset) begin
      r_trace_reads  <= 1'b0;
      r_trace_writes <= 1'b0;
      r_rd_lat       <= c_rd_lat_rst;
      r_wr_lat       <= c_wr_lat_rst;
    end else if (config_strobe && (config_addr == CFG_ADDR)) begin
      r_trace_reads  <= config_data[0];
      r_trace_writes <= config_data[1];
      r_rd_lat       <= config_data[7:4];
      r_wr_lat       <= config_data[11:8];
    end
  end

  // Packet selection: first matching rule wins, at most one packet per cycle
  always_comb begin
    w_gen         = 1'b0;
    w_gen_type    = c_type_addr;
    w_gen_payload = '0;
    w_ts_next     = r_ts;
    if (filter_strobe) begin
      w_ts_next = r_ts + c_ts_one;
      if (w_trace_any && filter_addr_latch) begin
        w_gen         = 1'b1;
        w_gen_type    = c_type_addr;
        w_gen_payload = filter_a;
      end else if (r_trace_writes && filter_write && w_wr_due) begin
        w_gen         = 1'b1;
        w_gen_type    = c_type_write;
        w_gen_payload = {w_ts5, filter_ublb, filter_d};
        w_ts_next     = r_ts - w_ts5_ext;
      end else if (r_trace_reads && filter_read && w_rd_due) begin
        w_gen         = 1'b1;
        w_gen_type    = c_type_read;
        w_gen_payload = {w_ts5, filter_ublb, nfilter_d};
        w_ts_next     = r_ts - w_ts5_ext;
      end else if (w_trace_any &&
                   (((r_burst == 8'd1) && (r_ts != w_ts5_ext)) || r_ts[ADDR_WIDTH-2])) begin
        // Full timestamp resync; the payload MSB is guaranteed zero here
        w_gen         = 1'b1;
        w_gen_type    = c_type_ts;
        w_gen_payload = r_ts;
        w_ts_next     = '0;
      end
    end
  end

  // Timestamp and burst position advance on qualified bus samples only
  always_ff @(posedge mclk) begin
    if (reset) begin
      r_ts    <= '0;
      r_burst <= 8'd0;
    end else if (filter_strobe) begin
      r_ts <= w_ts_next;
      if (filter_addr_latch) begin
        r_burst <= 8'd0;
      end else if ((filter_read || filter_write) && (r_burst != 8'hFF)) begin
        r_burst <= r_burst + 8'd1;
      end
    end
  end

  // Fullness is judged before any pop in the same cycle
  assign w_full      = (r_level == c_lvl_full);
  assign w_drop      = w_gen && w_full;
  assign w_marker    = r_drop_pending && !w_gen && !w_full;
  assign w_push      = (w_gen && !w_full) || w_marker;
  assign w_pop       = packet_valid && packet_ready;
  assign w_push_word = w_marker ? {c_type_ts, 1'b1, r_drop_count}
                                : {w_gen_type, w_gen_payload};

  // Drop accounting and overflow-marker bookkeeping
  always_ff @(posedge mclk) begin
    if (reset) begin
      r_drop_count   <= '0;
      r_drop_pending <= 1'b0;
    end else if (w_drop) begin
      r_drop_pending <= 1'b1;
      if (!(&r_drop_count)) begin
        r_drop_count <= r_drop_count + (ADDR_WIDTH-1)'(1);
      end
    end else if (w_marker) begin
      r_drop_pending <= 1'b0;
      r_drop_count   <= '0;
    end
  end

  // FIFO storage write; contents are masked at the output while empty
  always_ff @(posedge mclk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_word;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge mclk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + c_lvl_one;
        2'b01:   r_level <= r_level - c_lvl_one;
        default: r_level <= r_level;
      endcase
    end
  end

  assign packet_valid = (r_level != '0);
  assign fifo_level   = r_level;
  assign drop_pending = r_drop_pending;

  // Head of FIFO, forced to zero while empty
  always_comb begin
    {packet_type, packet_payload} = '0;
    if (packet_valid) begin
      {packet_type, packet_payload} = r_mem[r_rd_ptr];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_trace_packetizer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_trace_packetizer                                          |
// | Description : Directed bench for trace_packetizer with a queue-based       |
// |               reference model compared against the outputs every cycle.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_trace_packetizer;

  localparam int AW    = 23;
  localparam int DW    = 16;
  localparam int DEPTH = 16;

  logic          mclk = 1'b0;
  logic          reset;
  logic [15:0]   config_addr;
  logic [15:0]   config_data;
  logic          config_strobe;
  logic [AW-1:0] filter_a;
  logic [DW-1:0] filter_d;
  logic [DW-1:0] nfilter_d;
  logic [1:0]    filter_ublb;
  logic          filter_read;
  logic          filter_write;
  logic          filter_addr_latch;
  logic          filter_strobe;
  logic [1:0]    packet_type;
  logic [AW-1:0] packet_payload;
  logic          packet_valid;
  logic          packet_ready;
  logic [4:0]    fifo_level;
  logic          drop_pending;

  always #5 mclk = ~mclk;

  trace_packetizer dut (
    .mclk              (mclk),
    .reset             (reset),
    .config_addr       (config_addr),
    .config_data       (config_data),
    .config_strobe     (config_strobe),
    .filter_a          (filter_a),
    .filter_d          (filter_d),
    .nfilter_d         (nfilter_d),
    .filter_ublb       (filter_ublb),
    .filter_read       (filter_read),
    .filter_write      (filter_write),
    .filter_addr_latch (filter_addr_latch),
    .filter_strobe     (filter_strobe),
    .packet_type       (packet_type),
    .packet_payload    (packet_payload),
    .packet_valid      (packet_valid),
    .packet_ready      (packet_ready),
    .fifo_level        (fifo_level),
    .drop_pending      (drop_pending)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model state: queue of {type, payload} words plus counters
  logic [AW+1:0] mq[$];
  logic [AW-1:0] m_ts;
  int            m_burst;
  logic [AW-2:0] m_drops;
  bit            m_pend;
  bit            m_tr;
  bit            m_tw;
  int            m_rdl;
  int            m_wrl;
  bit            chk_en = 1'b0;
  logic [AW+1:0] cmp_head;

  // One clock edge of the model, evaluated from the inputs presented at that edge
  task automatic mstep();
    bit            full;
    bit            any;
    bit            gen;
    logic [1:0]    ty;
    logic [AW-1:0] pl;
    logic [AW-1:0] ts5;
    logic [AW-1:0] nts;
    int            rth;
    int            wth;
    if (reset) begin
      mq.delete();
      m_ts = '0; m_burst = 0; m_drops = '0; m_pend = 1'b0;
      m_tr = 1'b0; m_tw = 1'b0; m_rdl = 4; m_wrl = 3;
      return;
    end
    full = (mq.size() == DEPTH);
    any  = m_tr || m_tw;
    gen  = 1'b0; ty = 2'b00; pl = '0; nts = m_ts;
    ts5  = (m_ts > 31) ? AW'(31) : m_ts;
    rth  = ((m_rdl == 0) ? 1 : m_rdl) - 1;
    wth  = ((m_wrl == 0) ? 1 : m_wrl) - 1;
    if (filter_strobe) begin
      nts = m_ts + AW'(1);
      if (any && filter_addr_latch) begin
        gen = 1'b1; ty = 2'b00; pl = filter_a;
      end else if (m_tw && filter_write && m_burst >= wth) begin
        gen = 1'b1; ty = 2'b10; pl = {ts5[4:0], filter_ublb, filter_d}; nts = m_ts - ts5;
      end else if (m_tr && filter_read && m_burst >= rth) begin
        gen = 1'b1; ty = 2'b01; pl = {ts5[4:0], filter_ublb, nfilter_d}; nts = m_ts - ts5;
      end else if (any && (((m_burst == 1) && (m_ts != ts5)) || m_ts[AW-2])) begin
        gen = 1'b1; ty = 2'b11; pl = m_ts; nts = '0;
      end
      if (filter_addr_latch) m_burst = 0;
      else if (filter_read || filter_write) m_burst = (m_burst == 255) ? 255 : m_burst + 1;
    end
    if ((mq.size() > 0) && packet_ready) void'(mq.pop_front());
    if (gen) begin
      if (full) begin
        if (m_drops != '1) m_drops = m_drops + 1'b1;
        m_pend = 1'b1;
      end else begin
        mq.push_back({ty, pl});
      end
    end else if (m_pend && !full) begin
      mq.push_back({2'b11, 1'b1, m_drops});
      m_drops = '0;
      m_pend  = 1'b0;
    end
    if (config_strobe && (config_addr == 16'h0001)) begin
      m_tr  = config_data[0];
      m_tw  = config_data[1];
      m_rdl = int'(config_data[7:4]);
      m_wrl = int'(config_data[11:8]);
    end
    m_ts = nts;
  endtask

  // Every cycle: outputs must match the model's queue head, occupancy and marker flag
  always @(negedge mclk) begin
    if (chk_en) begin
      cmp_head = (mq.size() > 0) ? mq[0] : '0;
      check("valid", packet_valid, (mq.size() > 0));
      check("level", fifo_level, mq.size());
      check("drop_pending", drop_pending, m_pend);
      check("head", {packet_type, packet_payload}, cmp_head);
    end
  end

  task automatic tick(input bit stb, input bit lat, input bit rd, input bit wr,
                      input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] nd);
    filter_strobe     = stb;
    filter_addr_latch = lat;
    filter_read       = rd;
    filter_write      = wr;
    filter_a          = a;
    filter_d          = d;
    nfilter_d         = nd;
    @(posedge mclk);
    mstep();
    @(negedge mclk);
    config_strobe = 1'b0;
  endtask

  task automatic nop();
    tick(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic do_latch(input logic [AW-1:0] a);
    tick(1'b1, 1'b1, 1'b0, 1'b0, a, 16'h0000, 16'h0000);
  endtask

  task automatic do_read(input logic [DW-1:0] nd);
    tick(1'b1, 1'b0, 1'b1, 1'b0, '0, 16'h5A5A, nd);
  endtask

  task automatic do_write(input logic [DW-1:0] d);
    tick(1'b1, 1'b0, 1'b0, 1'b1, '0, d, 16'hA5A5);
  endtask

  task automatic do_cfg(input logic [15:0] addr, input logic [15:0] data);
    config_addr   = addr;
    config_data   = data;
    config_strobe = 1'b1;
    nop();
  endtask

  task automatic expect_head(input string name, input logic [1:0] t, input logic [AW-1:0] p);
    check(name, {packet_type, packet_payload}, {t, p});
  endtask

  initial begin
    reset = 1'b1; config_addr = '0; config_data = '0; config_strobe = 1'b0;
    filter_a = '0; filter_d = '0; nfilter_d = '0; filter_ublb = 2'b11;
    filter_read = 1'b0; filter_write = 1'b0; filter_addr_latch = 1'b0; filter_strobe = 1'b0;
    packet_ready = 1'b1;
    @(negedge mclk);
    nop();
    nop();
    reset  = 1'b0;
    chk_en = 1'b1;
    check("rst_valid", packet_valid, 1'b0);
    check("rst_level", fifo_level, 5'd0);
    check("rst_pending", drop_pending, 1'b0);

    // Tracing is off out of reset; a write to another address changes nothing
    do_latch(23'h000777);
    check("disabled_latch", packet_valid, 1'b0);
    do_cfg(16'h0002, 16'h0343);
    do_latch(23'h000777);
    check("wrong_cfg_addr", packet_valid, 1'b0);

    // Read burst, rd_lat 4 (ts reaches 6 before the first read packet)
    do_cfg(16'h0001, 16'h0343);
    do_latch(23'h123456);
    expect_head("addr_pkt", 2'b00, 23'h123456);
    for (int i = 0; i < 3; i++) do_read(16'hBEEF);
    do_read(16'hBEEF);
    expect_head("read_pkt1", 2'b01, 23'h1BBEEF);
    do_read(16'hBEEF);
    expect_head("read_pkt2", 2'b01, 23'h03BEEF);

    // Write burst, wr_lat 3: packets on the 3rd and 4th strobes only
    do_latch(23'h000042);
    do_write(16'h1234);
    check("write1_none", packet_valid, 1'b0);
    do_write(16'h1234);
    check("write2_none", packet_valid, 1'b0);
    do_write(16'h1234);
    expect_head("write_pkt1", 2'b10, 23'h0F1234);
    do_write(16'h1234);
    expect_head("write_pkt2", 2'b10, 23'h031234);

    // Long idle: ts5 saturates at 31, remainder 9 carries into the next packet
    idle(40);
    do_read(16'hBEEF);
    expect_head("ts5_sat", 2'b01, 23'h7FBEEF);
    do_read(16'hBEEF);
    expect_head("ts5_rem", 2'b01, 23'h27BEEF);
    idle(40);
    do_latch(23'h000100);
    do_read(16'hBEEF);
    do_read(16'hBEEF);
    expect_head("sync_pkt", 2'b11, 23'h00002A);

    // Latency field 0 behaves as 1; writes not traced
    do_cfg(16'h0001, 16'h0001);
    do_latch(23'h000200);
    do_read(16'hBEEF);
    expect_head("lat0_read", 2'b01, 23'h07BEEF);
    do_write(16'h1234);
    check("untraced_write", packet_valid, 1'b0);
    do_cfg(16'h0001, 16'h0343);

    // Overflow: 20 address packets into a 16-deep FIFO with no consumer
    packet_ready = 1'b0;
    for (int i = 0; i < 20; i++) do_latch(23'h000100 + 23'(i));
    check("ovf_level", fifo_level, 5'd16);
    check("ovf_pending", drop_pending, 1'b1);
    check("model_drops", m_drops, 22'd4);
    packet_ready = 1'b1;
    idle(1);
    expect_head("drain_first", 2'b00, 23'h000101);
    idle(15);
    expect_head("marker", 2'b11, 23'h400004);
    check("marker_clr", drop_pending, 1'b0);
    idle(1);
    check("drained", packet_valid, 1'b0);

    // Timestamp bit ADDR_WIDTH-2 set with no traffic forces a resync to 0
    force dut.r_ts = 23'h200000;
    m_ts = 23'h200000;
    nop();
    release dut.r_ts;
    idle(1);
    expect_head("ts_msb_sync", 2'b11, 23'h200000);
    idle(1);
    check("ts_restart", packet_valid, 1'b0);

    // Reset with a full FIFO and an owed marker
    packet_ready = 1'b0;
    for (int i = 0; i < 17; i++) do_latch(23'h000300 + 23'(i));
    check("pre_rst_level", fifo_level, 5'd16);
    check("pre_rst_pending", drop_pending, 1'b1);
    reset = 1'b1;
    nop();
    reset = 1'b0;
    check("mid_rst_valid", packet_valid, 1'b0);
    check("mid_rst_level", fifo_level, 5'd0);
    check("mid_rst_pending", drop_pending, 1'b0);
    packet_ready = 1'b1;
    do_latch(23'h000555);
    idle(3);
    check("post_rst_quiet", fifo_level, 5'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
